// File: rtl/bus_initiator.sv
`default_nettype none
// ============================================================================
//  Module      : bus_initiator
//  Description : Clocked initiator for the native parallel bus. Turns one
//                valid/ready request at a time into a bus cycle on
//                r_wn/addr/wdata and returns a valid/ready response.
//                Writes commit on the falling edge of r_wn; reads sample the
//                OR-combined endpoint rdata after READ_WAIT cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_initiator #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int READ_WAIT  = 2,
    parameter int WR_LOW     = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_r_wn,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_r_wn,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  r_wn,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] wdata,
    input  logic [DATA_WIDTH-1:0] rdata
);

    // One shared down-counter serves both the read wait and the write low phase
    localparam int CNT_MAX = (READ_WAIT > WR_LOW) ? READ_WAIT : WR_LOW;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] RD_CNT_INIT = CNT_W'(READ_WAIT - 1);
    localparam logic [CNT_W-1:0] WR_CNT_INIT = CNT_W'(WR_LOW - 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WR_SETUP = 3'd1;
    localparam logic [2:0] S_WR_LOW   = 3'd2;
    localparam logic [2:0] S_WR_HOLD  = 3'd3;
    localparam logic [2:0] S_RD_WAIT  = 3'd4;
    localparam logic [2:0] S_RESP     = 3'd5;

    logic [2:0]            state_q,     state_d;
    logic [CNT_W-1:0]      cnt_q,       cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q,      addr_d;
    logic [DATA_WIDTH-1:0] wdata_q,     wdata_d;
    logic                  r_wn_q,      r_wn_d;
    logic                  req_ready_q, req_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_r_wn_q,  rsp_r_wn_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  accept;

    assign accept = req_valid && req_ready_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: fixed setup/hold around the write low phase
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (accept) state_d = req_r_wn ? S_RD_WAIT : S_WR_SETUP;
            S_WR_SETUP: state_d = S_WR_LOW;
            S_WR_LOW:   if (cnt_q == '0) state_d = S_WR_HOLD;
            S_WR_HOLD:  state_d = S_RESP;
            S_RD_WAIT:  if (cnt_q == '0) state_d = S_RESP;
            S_RESP:     if (rsp_ready) state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // Output/datapath next values; every port is driven from a register
    always_comb begin
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_r_wn_d  = rsp_r_wn_q;
        rsp_rdata_d = rsp_rdata_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cnt_d   = RD_CNT_INIT;
                end
            end
            S_WR_SETUP: cnt_d = WR_CNT_INIT;
            S_WR_LOW: begin
                if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
            end
            S_WR_HOLD: begin
                rsp_valid_d = 1'b1;
                rsp_r_wn_d  = 1'b0;
                rsp_rdata_d = '0;
            end
            S_RD_WAIT: begin
                if (cnt_q == '0) begin
                    rsp_valid_d = 1'b1;
                    rsp_r_wn_d  = 1'b1;
                    rsp_rdata_d = rdata;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready) rsp_valid_d = 1'b0;
            end
            default: ;
        endcase
        // r_wn falls only on entry to the write low phase
        r_wn_d      = (state_d != S_WR_LOW);
        req_ready_d = (state_d == S_IDLE) && !rsp_valid_d;
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            r_wn_q      <= 1'b1;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_r_wn_q  <= 1'b1;
            rsp_rdata_q <= '0;
        end else begin
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            r_wn_q      <= r_wn_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_r_wn_q  <= rsp_r_wn_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_r_wn  = rsp_r_wn_q;
    assign rsp_rdata = rsp_rdata_q;
    assign r_wn      = r_wn_q;
    assign addr      = addr_q;
    assign wdata     = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_initiator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bus_initiator
//  Description : Self-checking bench for bus_initiator with two behavioural
//                16-byte endpoints (base 0 and base 16) on the shared bus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_initiator;

    localparam int RW = 2;
    localparam int WL = 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_r_wn = 1'b1;
    logic [7:0] req_addr = '0;
    logic [7:0] req_wdata = '0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b1;
    logic       rsp_r_wn;
    logic [7:0] rsp_rdata;
    logic       r_wn;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;

    int total = 0;
    int bad   = 0;
    int fall_cnt = 0;

    typedef struct {
        logic       rw;
        logic [7:0] data;
    } exp_t;
    exp_t sb_q[$];
    exp_t mon_e;

    logic [7:0] ep_mem    [0:31];
    logic [7:0] model_mem [0:255];

    always #5 clk = ~clk;

    bus_initiator #(
        .ADDR_WIDTH(8), .DATA_WIDTH(8), .READ_WAIT(RW), .WR_LOW(WL)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_r_wn(req_r_wn),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_r_wn(rsp_r_wn),
        .rsp_rdata(rsp_rdata),
        .r_wn(r_wn), .addr(addr), .wdata(wdata), .rdata(rdata)
    );

    // Endpoints: base 0 and base 16, range 16 each; commit on r_wn falling edge
    always @(negedge r_wn) begin
        fall_cnt <= fall_cnt + 1;
        if (addr < 8'd32) ep_mem[addr[4:0]] <= wdata;
    end
    assign rdata = (r_wn && addr < 8'd32) ? ep_mem[addr[4:0]] : 8'h00;

    // Scoreboard consumer: compares each response handshake with the queue head
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL sb_empty: unexpected response r_wn=%b rdata=%h", rsp_r_wn, rsp_rdata);
            end else begin
                mon_e = sb_q.pop_front();
                if (rsp_r_wn !== mon_e.rw || rsp_rdata !== mon_e.data) begin
                    bad++;
                    $display("FAIL sb_rsp: got r_wn=%b rdata=%h expected r_wn=%b rdata=%h",
                             rsp_r_wn, rsp_rdata, mon_e.rw, mon_e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push_exp(input logic rw, input logic [7:0] a, input logic [7:0] d);
        exp_t e;
        e.rw = rw;
        if (!rw) begin
            if (a < 8'd32) model_mem[a] = d;
            e.data = 8'h00;
        end else begin
            e.data = (a < 8'd32) ? model_mem[a] : 8'h00;
        end
        sb_q.push_back(e);
    endtask

    // Present a request and return just after the accepting edge
    task automatic send(input logic rw, input logic [7:0] a, input logic [7:0] d);
        bit ok;
        ok = 1'b0;
        req_valid = 1'b1;
        req_r_wn  = rw;
        req_addr  = a;
        req_wdata = d;
        for (int n = 0; n < 50; n++) begin
            if (req_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL send_timeout: req_ready=%b required 1", req_ready);
            req_valid = 1'b0;
            return;
        end
        tick();
        req_valid = 1'b0;
        push_exp(rw, a, d);
    endtask

    // Count cycles from the first post-accept cycle to rsp_valid
    task automatic wait_rsp(output int lat);
        lat = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            lat++;
            if (rsp_valid === 1'b1) return;
        end
        total++;
        bad++;
        $display("FAIL rsp_timeout: rsp_valid=%b required 1", rsp_valid);
        lat = -1;
    endtask

    task automatic test_reset();
        int lat;
        rst_n = 1'b0;
        tick(); tick();
        @(negedge clk);
        total++;
        if ({r_wn, addr, wdata, req_ready, rsp_valid, rsp_rdata, rsp_r_wn} !==
            {1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1}) begin
            bad++;
            $display("FAIL reset_vals: r_wn=%b addr=%h wdata=%h rdy=%b rv=%b rd=%h rrw=%b required 1 00 00 0 0 00 1",
                     r_wn, addr, wdata, req_ready, rsp_valid, rsp_rdata, rsp_r_wn);
        end
        tick();
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        total++;
        if (req_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_release_ready: req_ready=%b required 1", req_ready);
        end
        // Reset in the middle of the write low phase
        tick();
        send(1'b0, 8'h05, 8'h3C);
        tick();
        total++;
        if (r_wn !== 1'b0) begin
            bad++;
            $display("FAIL wr_low_reached: r_wn=%b required 0", r_wn);
        end
        #1 rst_n = 1'b0;
        #1;
        total++;
        if ({r_wn, req_ready, rsp_valid} !== 3'b100) begin
            bad++;
            $display("FAIL async_reset: r_wn/req_ready/rsp_valid=%b required 100",
                     {r_wn, req_ready, rsp_valid});
        end
        sb_q.delete();
        tick(); tick();
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        total++;
        if (req_ready !== 1'b1 || r_wn !== 1'b1) begin
            bad++;
            $display("FAIL reset_idle: req_ready=%b r_wn=%b required 1 1", req_ready, r_wn);
        end
        // The interrupted write had already committed
        tick();
        send(1'b1, 8'h05, 8'h00);
        wait_rsp(lat);
    endtask

    task automatic test_write_read();
        int lat;
        tick();
        send(1'b0, 8'h03, 8'hA5);
        wait_rsp(lat);
        total++;
        if (lat != WL + 3) begin
            bad++;
            $display("FAIL write_latency: got %0d required %0d", lat, WL + 3);
        end
        tick();
        send(1'b1, 8'h03, 8'h00);
        wait_rsp(lat);
        total++;
        if (lat != RW + 1) begin
            bad++;
            $display("FAIL read_latency: got %0d required %0d", lat, RW + 1);
        end
        total++;
        if (rsp_rdata !== 8'hA5 || rsp_r_wn !== 1'b1) begin
            bad++;
            $display("FAIL read_back: rdata=%h r_wn=%b required a5 1", rsp_rdata, rsp_r_wn);
        end
    endtask

    task automatic test_write_waveform();
        int lat, lowc, low_at, f0;
        bit stable, setup_hi;
        tick();
        f0 = fall_cnt;
        send(1'b0, 8'h07, 8'h5A);
        lat = 0; lowc = 0; low_at = 0; stable = 1'b1; setup_hi = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            lat++;
            if (rsp_valid === 1'b1) break;
            if (n == 0) setup_hi = (r_wn === 1'b1);
            if (r_wn === 1'b0) begin
                lowc++;
                if (low_at == 0) low_at = lat;
            end
            if (addr !== 8'h07 || wdata !== 8'h5A) stable = 1'b0;
        end
        total++;
        if (lat != WL + 3) begin
            bad++;
            $display("FAIL wave_latency: got %0d required %0d", lat, WL + 3);
        end
        total++;
        if (lowc != WL || low_at != 2 || !setup_hi) begin
            bad++;
            $display("FAIL wave_low_pulse: low cycles=%0d first low=%0d setup_hi=%0d required %0d 2 1",
                     lowc, low_at, setup_hi, WL);
        end
        total++;
        if (!stable) begin
            bad++;
            $display("FAIL wave_stable: addr/wdata changed, now %h/%h required 07/5a", addr, wdata);
        end
        total++;
        if (fall_cnt - f0 != 1) begin
            bad++;
            $display("FAIL wave_falls: got %0d falling edges required 1", fall_cnt - f0);
        end
        tick();
        f0 = fall_cnt;
        send(1'b1, 8'h07, 8'h00);
        wait_rsp(lat);
        total++;
        if (fall_cnt != f0) begin
            bad++;
            $display("FAIL read_no_fall: got %0d falling edges required 0", fall_cnt - f0);
        end
    endtask

    task automatic test_backpressure();
        int lat, f0;
        logic [7:0] sr, sa;
        logic sw;
        tick();
        rsp_ready = 1'b0;
        send(1'b1, 8'h03, 8'h00);
        wait_rsp(lat);
        sr = rsp_rdata; sw = rsp_r_wn; sa = addr;
        tick();
        req_valid = 1'b1; req_r_wn = 1'b0; req_addr = 8'h09; req_wdata = 8'h77;
        f0 = fall_cnt;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            total++;
            if ({rsp_valid, rsp_rdata, rsp_r_wn, req_ready, r_wn, addr} !==
                {1'b1, sr, sw, 1'b0, 1'b1, sa}) begin
                bad++;
                $display("FAIL bp_hold: rv=%b rd=%h rrw=%b rdy=%b r_wn=%b addr=%h required 1 %h %b 0 1 %h",
                         rsp_valid, rsp_rdata, rsp_r_wn, req_ready, r_wn, addr, sr, sw, sa);
            end
        end
        tick();
        rsp_ready = 1'b1;
        @(negedge clk);
        total++;
        if (req_ready !== 1'b0) begin
            bad++;
            $display("FAIL bp_handshake_ready: req_ready=%b required 0", req_ready);
        end
        tick();
        total++;
        if (req_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_ready_after: req_ready=%b required 1", req_ready);
        end
        tick();
        req_valid = 1'b0;
        push_exp(1'b0, 8'h09, 8'h77);
        wait_rsp(lat);
        total++;
        if (lat != WL + 3 || fall_cnt - f0 != 1) begin
            bad++;
            $display("FAIL bp_queued_write: latency=%0d falls=%0d required %0d 1",
                     lat, fall_cnt - f0, WL + 3);
        end
    endtask

    task automatic test_two_endpoints();
        int lat;
        tick();
        send(1'b0, 8'h12, 8'h11);
        wait_rsp(lat);
        tick();
        send(1'b1, 8'h02, 8'h00);
        wait_rsp(lat);
        total++;
        if (rsp_rdata !== 8'h00) begin
            bad++;
            $display("FAIL ep0_read: rdata=%h required 00", rsp_rdata);
        end
        tick();
        send(1'b1, 8'h12, 8'h00);
        wait_rsp(lat);
        total++;
        if (rsp_rdata !== 8'h11) begin
            bad++;
            $display("FAIL ep1_read: rdata=%h required 11", rsp_rdata);
        end
        tick();
        send(1'b1, 8'hF0, 8'h00);
        wait_rsp(lat);
        total++;
        if (rsp_rdata !== 8'h00) begin
            bad++;
            $display("FAIL unmapped_read: rdata=%h required 00", rsp_rdata);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic rw;
        logic [7:0] a, d;
        rsp_ready = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            rw = 1'($urandom_range(0, 1));
            a  = 8'($urandom_range(0, 39));
            d  = 8'($urandom);
            send(rw, a, d);
            wait_rsp(lat);
            total++;
            if (lat != (rw ? RW + 1 : WL + 3)) begin
                bad++;
                $display("FAIL b2b_latency: txn %0d got %0d required %0d",
                         i, lat, rw ? RW + 1 : WL + 3);
            end
            tick();
            total++;
            if (req_ready !== 1'b1) begin
                bad++;
                $display("FAIL b2b_ready: txn %0d req_ready=%b required 1", i, req_ready);
            end
        end
        tick(); tick();
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL sb_drain: %0d entries left required 0", sb_q.size());
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) ep_mem[i] = 8'h00;
        for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;
        test_reset();
        test_write_read();
        test_write_waveform();
        test_backpressure();
        test_two_endpoints();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
